// File: rtl/wb_openram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-OpenRAM port-0 bridge.
//   state_t  : bridge FSM states
//   SRAM_*   : geometry of the 32x256 OpenRAM macro (address, data, mask widths)
//   WIN_*    : size of the decoded Wishbone window and its lowest compared bit
package wb_openram_pkg;

    localparam int unsigned SRAM_AW  = 8;
    localparam int unsigned SRAM_DW  = 32;
    localparam int unsigned SRAM_MW  = 4;

    localparam int unsigned WIN_SIZE = 1024;
    localparam int unsigned WIN_LSB  = $clog2(WIN_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/wb_openram_bridge.sv
// Wishbone classic slave driving port 0 (read/write) of a 32x256 OpenRAM macro.
// Decodes a 1 KB window at BASE_ADDR, issues one registered SRAM command,
// waits READ_LATENCY cycles for read data, then returns registered data with
// a single-cycle ack.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock (also the SRAM clk0) and synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i Wishbone cycle, strobe, write enable
//   wbs_sel_i            byte selects (become the SRAM write mask on writes)
//   wbs_adr_i            byte address; [31:10] decoded, [9:2] word address
//   wbs_dat_i            write data
//   wbs_ack_o            registered single-cycle acknowledge
//   wbs_dat_o            registered read data, holds last read value
//   sram_csb0/web0       active-low chip select / write enable
//   sram_wmask0          byte write mask
//   sram_addr0/din0      word address / write data
//   sram_dout0           read data from the macro
module wb_openram_bridge
    import wb_openram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [SRAM_MW-1:0] wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [SRAM_DW-1:0] wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [SRAM_DW-1:0] wbs_dat_o,
    output logic               sram_csb0,
    output logic               sram_web0,
    output logic [SRAM_MW-1:0] sram_wmask0,
    output logic [SRAM_AW-1:0] sram_addr0,
    output logic [SRAM_DW-1:0] sram_din0,
    input  logic [SRAM_DW-1:0] sram_dout0
);

    localparam int unsigned      CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic             op_write;
    logic             hit;

    // Byte-lane bits of the address carry no information for a word-wide macro.
    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^wbs_adr_i[1:0];

    assign hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            op_write    <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Every request field is captured here, so the master may
                    // change them freely once the command is accepted.
                    if (hit) begin
                        sram_csb0   <= 1'b0;
                        sram_web0   <= ~wbs_we_i;
                        sram_wmask0 <= wbs_we_i ? wbs_sel_i : '0;
                        sram_addr0  <= wbs_adr_i[SRAM_AW+1:2];
                        sram_din0   <= wbs_dat_i;
                        op_write    <= wbs_we_i;
                        state       <= CMD;
                    end
                end

                CMD: begin
                    // The macro samples the command at the edge ending this
                    // cycle; it completes even if the master abandons the cycle.
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (op_write) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        lat_cnt <= CNT_LOAD;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (lat_cnt == '0) begin
                        wbs_dat_o <= sram_dout0;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_openram_bridge.sv
module tb_wb_openram_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] adr   [2];
    logic [31:0] dat_i [2];
    logic        ack   [2];
    logic [31:0] dat_o [2];
    logic        csb   [2];
    logic        web   [2];
    logic [3:0]  wmask [2];
    logic [7:0]  addr0 [2];
    logic [31:0] din0  [2];
    logic [31:0] dout0 [2];

    wb_openram_bridge #(.BASE_ADDR(BASE), .READ_LATENCY(LAT0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
        .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dat_i[0]),
        .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]),
        .sram_csb0(csb[0]), .sram_web0(web[0]), .sram_wmask0(wmask[0]),
        .sram_addr0(addr0[0]), .sram_din0(din0[0]), .sram_dout0(dout0[0])
    );

    wb_openram_bridge #(.BASE_ADDR(BASE), .READ_LATENCY(LAT1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
        .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dat_i[1]),
        .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]),
        .sram_csb0(csb[1]), .sram_web0(web[1]), .sram_wmask0(wmask[1]),
        .sram_addr0(addr0[1]), .sram_din0(din0[1]), .sram_dout0(dout0[1])
    );

    // Behavioural OpenRAM port 0: samples the command on the rising edge; read
    // data is garbage until it becomes stable L edges after the sampling edge.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        localparam int unsigned L = (g == 0) ? LAT0 : LAT1;
        logic [31:0] mem [256] = '{default: '0};
        logic [31:0] dout_q   = '0;
        logic [31:0] pend_val = '0;
        int unsigned pend     = 0;
        assign dout0[g] = dout_q;
        always @(posedge clk) begin
            if (!csb[g]) begin
                if (!web[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[g][b]) mem[addr0[g]][8*b +: 8] <= din0[g][8*b +: 8];
                end else if (L == 1) begin
                    dout_q <= mem[addr0[g]];
                end else begin
                    dout_q   <= 32'hBAD0_0BAD;
                    pend_val <= mem[addr0[g]];
                    pend     <= L - 1;
                end
            end else if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) dout_q <= pend_val;
            end
        end
    end

    // Reference model: word memory plus the last value a read returned.
    logic [31:0] ref_mem [2][256];
    logic [31:0] exp_dat [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return a[31:10] == BASE[31:10];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nv[8*b +: 8];
        return r;
    endfunction

    // One Wishbone transfer on DUT d, first stb cycle = cycle 0. drop >= 1 pulls
    // cyc/stb low from that cycle onward; -1 means the master waits for ack.
    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v, input int drop);
        int          csb_n, ack_n, csb_c, ack_c, exp_ack;
        bit          hit, dropped, ack_now;
        logic        web_s;
        logic [7:0]  addr_s, wa;
        logic [3:0]  wm_s;
        logic [31:0] din_s, ack_dat, exp_rd;
        string       p;
        p = $sformatf("d%0d@%h_%s", d, a, w ? "wr" : "rd");
        csb_n = 0; ack_n = 0; csb_c = -1; ack_c = -1;
        web_s = 1'b1; addr_s = '0; wm_s = '0; din_s = '0; ack_dat = '0;
        hit = in_window(a);
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_i[d] = v;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ack_now = ack[d];
            if (!csb[d]) begin
                csb_n++;
                if (csb_c < 0) begin
                    csb_c = c; web_s = web[d]; addr_s = addr0[d]; wm_s = wmask[d]; din_s = din0[d];
                end
            end
            if (ack_now) begin
                ack_n++;
                if (ack_c < 0) begin ack_c = c; ack_dat = dat_o[d]; end
            end
            @(posedge clk); #1;
            if (ack_now || (c + 1 == drop)) begin
                cyc[d] = 1'b0; stb[d] = 1'b0;
            end else if (cyc[d] && hit) begin
                we[d] = 1'($urandom); sel[d] = 4'($urandom);
                adr[d] = $urandom; dat_i[d] = $urandom;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;

        wa      = a[9:2];
        exp_ack = w ? 2 : 2 + int'(lat_of(d));
        if (!hit) begin
            check_eq({p, "_csb_cnt"}, 32'(csb_n), 32'd0);
            check_eq({p, "_ack_cnt"}, 32'(ack_n), 32'd0);
        end else begin
            check_eq({p, "_csb_cnt"}, 32'(csb_n), 32'd1);
            check_eq({p, "_csb_cyc"}, 32'(csb_c), 32'd1);
            check_eq({p, "_web"},     32'(web_s), 32'(!w));
            check_eq({p, "_addr"},    32'(addr_s), 32'(wa));
            check_eq({p, "_wmask"},   32'(wm_s), w ? 32'(s) : 32'd0);
            check_eq({p, "_din"},     din_s, v);
            exp_rd  = ref_mem[d][wa];
            if (w) ref_mem[d][wa] = merge(ref_mem[d][wa], v, s);
            dropped = (drop >= 1) && (drop < exp_ack);
            if (dropped) begin
                check_eq({p, "_ack_cnt_drop"}, 32'(ack_n), 32'd0);
            end else begin
                check_eq({p, "_ack_cnt"}, 32'(ack_n), 32'd1);
                check_eq({p, "_ack_cyc"}, 32'(ack_c), 32'(exp_ack));
                if (!w) begin
                    check_eq({p, "_rdata"}, ack_dat, exp_rd);
                    exp_dat[d] = exp_rd;
                end
            end
        end
        check_eq({p, "_dat_hold"}, dat_o[d], exp_dat[d]);
    endtask

    // Write on DUT d with reset pulsed during its command cycle.
    task automatic rst_in_cmd(input int d, input logic [31:0] a, input logic [31:0] v);
        int    ack_n;
        string p;
        p = $sformatf("d%0d_rstcmd", d);
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; sel[d] = 4'hF; dat_i[d] = v;
        @(posedge clk); #1;
        rst[d] = 1'b1;
        @(negedge clk);
        check_eq({p, "_csb_in_cmd"}, 32'(csb[d]), 32'd0);
        @(posedge clk); #1;
        rst[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
        // The macro saw csb low on the same edge as reset, so the write lands.
        ref_mem[d][a[9:2]] = v;
        exp_dat[d] = '0;
        @(negedge clk);
        check_eq({p, "_csb"},   32'(csb[d]), 32'd1);
        check_eq({p, "_web"},   32'(web[d]), 32'd1);
        check_eq({p, "_ack"},   32'(ack[d]), 32'd0);
        check_eq({p, "_dat_o"}, dat_o[d], 32'd0);
        check_eq({p, "_wmask"}, 32'(wmask[d]), 32'd0);
        check_eq({p, "_addr"},  32'(addr0[d]), 32'd0);
        check_eq({p, "_din"},   din0[d], 32'd0);
        ack_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[d]) ack_n++;
        end
        check_eq({p, "_no_ack"}, 32'(ack_n), 32'd0);
    endtask

    logic [31:0] edge_addrs [3] = '{32'h3000_0400, 32'h2FFF_FFFC, 32'h3000_03FC};

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = '0; adr[d] = '0; dat_i[d] = '0; exp_dat[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_ack", d),   32'(ack[d]), 32'd0);
            check_eq($sformatf("d%0d_rst_dat", d),   dat_o[d], 32'd0);
            check_eq($sformatf("d%0d_rst_csb", d),   32'(csb[d]), 32'd1);
            check_eq($sformatf("d%0d_rst_web", d),   32'(web[d]), 32'd1);
            check_eq($sformatf("d%0d_rst_wmask", d), 32'(wmask[d]), 32'd0);
            check_eq($sformatf("d%0d_rst_addr", d),  32'(addr0[d]), 32'd0);
            check_eq($sformatf("d%0d_rst_din", d),   din0[d], 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h3000_0010, 4'hF,    32'hDEAD_BEEF, -1);
            xfer(d, 1'b0, 32'h3000_0010, 4'hF,    32'h0,         -1);
            check_eq($sformatf("d%0d_rd_deadbeef", d), dat_o[d], 32'hDEAD_BEEF);
            xfer(d, 1'b1, 32'h3000_0010, 4'b0010, 32'h0000_AB00, -1);
            xfer(d, 1'b0, 32'h3000_0011, 4'h0,    32'h0,         -1);
            check_eq($sformatf("d%0d_rd_merge", d), dat_o[d], 32'hDEAD_ABEF);
            xfer(d, 1'b1, 32'h3000_0010, 4'h0,    32'hFFFF_FFFF, -1);
            xfer(d, 1'b0, 32'h3000_0010, 4'hF,    32'h0,         -1);
            check_eq($sformatf("d%0d_rd_sel0", d), dat_o[d], 32'hDEAD_ABEF);
            xfer(d, 1'b1, 32'h3000_0400, 4'hF,    32'h1111_1111, -1);
            xfer(d, 1'b0, 32'h2FFF_FFFC, 4'hF,    32'h0,         -1);
            xfer(d, 1'b1, 32'h3000_03FC, 4'hF,    32'hCAFE_F00D, -1);
            xfer(d, 1'b0, 32'h3000_03FC, 4'hF,    32'h0,         -1);
            check_eq($sformatf("d%0d_rd_top", d), dat_o[d], 32'hCAFE_F00D);
            xfer(d, 1'b1, 32'h3000_0008, 4'hF,    32'h1234_5678, -1);
            xfer(d, 1'b0, 32'h3000_0008, 4'hF,    32'h0,          2);
            check_eq($sformatf("d%0d_drop_hold", d), dat_o[d], 32'hCAFE_F00D);
            xfer(d, 1'b1, 32'h3000_0000, 4'hF,    32'h0BAD_F00D, -1);
            rst_in_cmd(d, 32'h3000_0020, 32'h5A5A_A5A5);
            xfer(d, 1'b0, 32'h3000_0020, 4'hF,    32'h0,         -1);
            check_eq($sformatf("d%0d_rd_after_rst", d), dat_o[d], 32'h5A5A_A5A5);

            for (int i = 0; i < 50; i++) begin
                logic [31:0] a;
                bit          w;
                int          drop, ea;
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r == 0)      a = $urandom;
                else if (r == 1) a = edge_addrs[$urandom_range(0, 2)];
                else             a = BASE | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                w    = 1'($urandom);
                ea   = w ? 2 : 2 + int'(lat_of(d));
                drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, ea - 1)) : -1;
                xfer(d, w, a, 4'($urandom), $urandom, drop);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_openram_bridge.md
Name: wb_openram_bridge

Overview:
Wishbone classic slave that drives port 0 (read/write) of the 32x256 OpenRAM macro. It sits between the management SoC Wishbone bus and the SRAM macro inside the user project wrapper. It decodes a 1 KB window, generates correctly timed csb0/web0/wmask0/addr0/din0, waits out the macro read latency, then returns registered data and a single-cycle ack.

Parameters:
BASE_ADDR, 32'h3000_0000, window base; only bits [31:10] are compared.
READ_LATENCY, 1, cycles from the SRAM sampling edge to dout0 being stable (legal range 1..4).

Ports:
wb_clk_i  input  1  single clock; also drives SRAM clk0 at wrapper level.
wb_rst_i  input  1  synchronous, active-high reset.
wbs_cyc_i  input  1  Wishbone cycle.
wbs_stb_i  input  1  Wishbone strobe.
wbs_we_i  input  1  1 = write.
wbs_sel_i  input  4  byte selects.
wbs_adr_i  input  32  byte address.
wbs_dat_i  input  32  write data.
wbs_ack_o  output  1  single-cycle acknowledge, registered.
wbs_dat_o  output  32  read data, registered.
sram_csb0  output  1  active-low chip select.
sram_web0  output  1  active-low write enable.
sram_wmask0  output  4  byte write mask.
sram_addr0  output  8  word address.
sram_din0  output  32  write data to SRAM.
sram_dout0  input  32  read data from SRAM.

Behaviour:
- Decided interface rule: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0. FSM goes to IDLE.
- Address hit condition: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10]==BASE_ADDR[31:10]).
- Word address is wbs_adr_i[9:2]. Bits [1:0] are ignored.
- Addresses outside the window are ignored: no csb, no ack. Another slave owns the response.
- All SRAM outputs are registered.
- FSM states: IDLE, CMD, WAIT, ACK.
- IDLE -> CMD on hit. At that edge, register csb0=0, web0=~we, wmask0=sel (writes) or 0 (reads), addr0, din0=dat_i.
- CMD lasts exactly 1 cycle with csb0=0. On exit, csb0 returns to 1 and web0 returns to 1.
  - Write: CMD -> ACK.
  - Read: CMD -> WAIT, with latency counter loaded to READ_LATENCY-1.
- WAIT: counter decrements each cycle. When it reaches 0, capture wbs_dat_o <= sram_dout0, assert ack, and move to ACK.
- ACK: wbs_ack_o=1 for exactly 1 cycle, then return to IDLE. No new request is accepted in the ACK cycle.
- Latency, counted from the first cycle stb is high:
  - Write: ack in cycle +2.
  - Read: ack in cycle +2+READ_LATENCY, so cycle +3 at the default.
- wbs_dat_o holds the last read value. Writes do not change it.
- Write with sel=0: csb is still issued with wmask0=0, the SRAM is unchanged, and ack is still given.
- cyc_i deasserted in CMD or WAIT:
  - The SRAM op already issued completes internally.
  - Ack is suppressed and wbs_dat_o is not updated.
  - FSM returns to IDLE next cycle.
- Reset asserted mid-operation: at the next edge all outputs take their reset values and state is IDLE. No ack is emitted.
- wbs_sel_i/wbs_we_i/wbs_adr_i changing after acceptance have no effect, because they are latched in IDLE.

Decomposition:
- Shared package wb_openram_pkg holds:
  - state enum {IDLE, CMD, WAIT, ACK};
  - SRAM_AW=8, SRAM_DW=32, SRAM_MW=4;
  - window size constant 1024.
- No sub-module; a single FSM plus latency counter. Counter width is $clog2(READ_LATENCY+1).

Test Plan:
- Write 0xDEADBEEF to 0x3000_0010, sel=4'hF -> in cycle +1: csb0=0 for 1 cycle, web0=0, addr0=8'h04, wmask0=4'hF, din0=DEADBEEF; ack in cycle +2 for exactly 1 cycle.
- Read 0x3000_0010 with a behavioural SRAM model (latency 1) -> csb0=0 and web0=1 in cycle +1; ack in cycle +3 with wbs_dat_o=0xDEADBEEF.
- Write sel=4'b0010, dat=0x0000AB00 to the same address, then read -> 0xDEADABEF. Also: write with sel=0, then read -> value unchanged.
- Access 0x3000_0400 and 0x2FFF_FFFC -> csb0 stays 1 and no ack for 10 cycles. Boundary 0x3000_03FC -> addr0=8'hFF and ack.
- Read with cyc_i dropped in the WAIT cycle -> no ack, wbs_dat_o unchanged. A following write to 0x3000_0000 completes normally.
- wb_rst_i pulsed during CMD of a write -> next cycle csb0=1, ack=0, wbs_dat_o=0, FSM IDLE. Repeat the read test with READ_LATENCY=3 -> ack in cycle +5.
